conv3x3_filter: RTL

CONV3X3_FILTER -- requirements
Module: conv3x3_filter

---
 rtl/conv3x3_filter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/conv3x3_filter.sv
// conv3x3_filter
//   Streaming 3x3 neighbourhood filter for a raster-scanned grey image.
//   Two line buffers feed a 3x3 window that shifts one column per de beat.
//   The selected kernel is evaluated from the window and registered, so a
//   result appears two cycles after the beat that completes its window.
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   x_coor   in   [9:0]        column of i_data
//   y_coor   in   [8:0]        row of i_data
//   de       in   i_data / x_coor / y_coor valid this cycle
//   i_data   in   [PIX_W-1:0]  input pixel
//   mode     in   [1:0]        00 bypass, 01 gaussian, 10 sharpen, 11 edge
//   o_valid  out  o_data valid this cycle
//   o_data   out  [PIX_W-1:0]  filtered pixel (held while o_valid is low)
module conv3x3_filter #(
  parameter int PIX_W      = 4,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       x_coor,
  input  logic [8:0]       y_coor,
  input  logic             de,
  input  logic [PIX_W-1:0] i_data,
  input  logic [1:0]       mode,
  output logic             o_valid,
  output logic [PIX_W-1:0] o_data
);

  localparam int AW = $clog2(IMG_WIDTH);
  localparam int SW = PIX_W + 4;

  localparam logic [1:0] MODE_BYPASS  = 2'b00;
  localparam logic [1:0] MODE_GAUSS   = 2'b01;
  localparam logic [1:0] MODE_SHARPEN = 2'b10;

  localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_HEIGHT - 1);

  localparam logic [SW-1:0]        PMAX_U = {4'b0000, {PIX_W{1'b1}}};
  localparam logic signed [SW-1:0] PMAX_S = $signed({4'b0000, {PIX_W{1'b1}}});

  logic [PIX_W-1:0] line_buf1 [IMG_WIDTH];
  logic [PIX_W-1:0] line_buf2 [IMG_WIDTH];
  logic [PIX_W-1:0] win [3][3];  // [row][col]; row 0 oldest line, col 0 leftmost

  logic [AW-1:0]    x_addr;
  logic             in_range;
  logic             frame_start;
  logic             qualify;
  logic             frame_seen;
  logic [1:0]       active_mode;
  logic             v1;
  logic [PIX_W-1:0] lb1_rd;
  logic [PIX_W-1:0] lb2_rd;

  assign x_addr      = x_coor[AW-1:0];
  assign in_range    = (x_coor <= X_LAST) && (y_coor <= Y_LAST);
  assign frame_start = de && (x_coor == 10'd0) && (y_coor == 9'd0);
  // Line buffers are stale until a frame start has been seen since reset.
  assign qualify     = de && in_range && frame_seen &&
                       (x_coor >= 10'd2) && (y_coor >= 9'd2);
  assign lb1_rd      = line_buf1[x_addr];
  assign lb2_rd      = line_buf2[x_addr];

  // Line buffers carry no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (de && in_range) begin
      line_buf2[x_addr] <= lb1_rd;
      line_buf1[x_addr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      v1          <= 1'b0;
      frame_seen  <= 1'b0;
      active_mode <= MODE_BYPASS;
    end else begin
      v1 <= qualify;
      if (de && in_range) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= i_data;
      end
      if (frame_start) begin
        frame_seen  <= 1'b1;
        active_mode <= mode;
      end
    end
  end

  function automatic logic [SW-1:0] zx(input logic [PIX_W-1:0] p);
    return {4'b0000, p};
  endfunction

  function automatic logic signed [SW-1:0] sx(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  logic [SW-1:0]        g_sum;
  logic signed [SW-1:0] s_val;
  logic signed [SW-1:0] gx;
  logic signed [SW-1:0] gy;
  logic [SW-1:0]        ax;
  logic [SW-1:0]        ay;
  logic [SW-1:0]        mag;
  logic [PIX_W-1:0]     filt;

  always_comb begin
    g_sum = zx(win[0][0]) + (zx(win[0][1]) << 1) + zx(win[0][2]) +
            (zx(win[1][0]) << 1) + (zx(win[1][1]) << 2) + (zx(win[1][2]) << 1) +
            zx(win[2][0]) + (zx(win[2][1]) << 1) + zx(win[2][2]);

    s_val = (sx(win[1][1]) <<< 2) + sx(win[1][1])
            - sx(win[0][1]) - sx(win[2][1]) - sx(win[1][0]) - sx(win[1][2]);

    gx = (sx(win[0][2]) + (sx(win[1][2]) <<< 1) + sx(win[2][2]))
       - (sx(win[0][0]) + (sx(win[1][0]) <<< 1) + sx(win[2][0]));
    gy = (sx(win[2][0]) + (sx(win[2][1]) <<< 1) + sx(win[2][2]))
       - (sx(win[0][0]) + (sx(win[0][1]) <<< 1) + sx(win[0][2]));
    ax  = gx[SW-1] ? -gx : gx;
    ay  = gy[SW-1] ? -gy : gy;
    // |Gx|+|Gy| is at most 8*max pixel, so it cannot wrap in SW bits.
    mag = ax + ay;

    filt = win[1][1];
    case (active_mode)
      MODE_BYPASS: filt = win[1][1];
      MODE_GAUSS:  filt = PIX_W'(g_sum >> 4);
      MODE_SHARPEN: begin
        if (s_val < 0)           filt = '0;
        else if (s_val > PMAX_S) filt = '1;
        else                     filt = s_val[PIX_W-1:0];
      end
      default: begin
        if (mag > PMAX_U) filt = '1;
        else              filt = mag[PIX_W-1:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= v1;
      if (v1)
        o_data <= filt;
    end
  end

endmodule
